// File: rtl/lsu_pkg.sv
// Shared load/store encodings, FSM state codes and alignment helpers.
// No logic of its own; latency and backpressure belong to the importers.
package lsu_pkg;

  localparam logic [2:0] MODE_B  = 3'b000;
  localparam logic [2:0] MODE_H  = 3'b001;
  localparam logic [2:0] MODE_W  = 3'b010;
  localparam logic [2:0] MODE_BU = 3'b100;
  localparam logic [2:0] MODE_HU = 3'b101;

  typedef logic [1:0] lsu_state_t;
  localparam lsu_state_t IDLE = 2'd0;
  localparam lsu_state_t REQ  = 2'd1;
  localparam lsu_state_t DONE = 2'd2;

  function automatic logic mode_legal(input logic [2:0] mode);
    logic ok;
    case (mode)
      MODE_B, MODE_H, MODE_W, MODE_BU, MODE_HU: ok = 1'b1;
      default:                                  ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic is_misaligned(input logic [2:0] mode, input logic [1:0] addr_lo);
    logic mis;
    case (mode)
      MODE_H, MODE_HU: mis = addr_lo[0];
      MODE_W:          mis = (addr_lo != 2'b00);
      default:         mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store enables/replication and load extraction with extension.
// Purely combinational, zero latency, no flow control.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  mode_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] bus_rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_lo_i)
      2'd0:    byte_sel = bus_rdata_i[7:0];
      2'd1:    byte_sel = bus_rdata_i[15:8];
      2'd2:    byte_sel = bus_rdata_i[23:16];
      default: byte_sel = bus_rdata_i[31:24];
    endcase
    half_sel = addr_lo_i[1] ? bus_rdata_i[31:16] : bus_rdata_i[15:0];

    be_o    = 4'h0;
    wdata_o = wdata_i;
    rdata_o = bus_rdata_i;
    case (mode_i)
      MODE_B: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = {{24{byte_sel[7]}}, byte_sel};
      end
      MODE_BU: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = {24'h0, byte_sel};
      end
      MODE_H: begin
        be_o    = 4'b0011 << {addr_lo_i[1], 1'b0};
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = {{16{half_sel[15]}}, half_sel};
      end
      MODE_HU: begin
        be_o    = 4'b0011 << {addr_lo_i[1], 1'b0};
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = {16'h0, half_sel};
      end
      MODE_W: begin
        be_o = 4'hF;
      end
      default: begin
        be_o = 4'h0;
      end
    endcase
  end

endmodule

// File: rtl/lsu_bus_if.sv
// Memory-stage load/store to valid/ready bus master; 3 cycles with a zero-wait slave.
// Stalls the pipeline while REQ waits on bus_ready; aborts as a fault after TIMEOUT_CYCLES.
module lsu_bus_if
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] addr,
  input  logic [2:0]  mem_acc_mode,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall_mem,
  output logic        misalign,
  output logic        access_fault,
  output logic        bus_valid,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata,
  input  logic        bus_err
);

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  lsu_state_t  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        fault_q, fault_d;
  logic        we_q, we_d;
  logic [29:0] addr_q, addr_d;
  logic [1:0]  alo_q, alo_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  mode_q, mode_d;

  logic        idle, req, legal, mis, req_ok;
  logic [2:0]  al_mode;
  logic [1:0]  al_alo;
  logic [3:0]  al_be;
  logic [31:0] al_wdata, al_rdata;

  // Reset gates the request so every output reads 0 while rst is low.
  assign idle   = (state_q == IDLE);
  assign req    = (rd_en | wr_en) & rst;
  assign legal  = mode_legal(mem_acc_mode);
  assign mis    = is_misaligned(mem_acc_mode, addr[1:0]);
  assign req_ok = idle & req & legal & ~mis;

  // Inputs steer lanes while accepting; the latched request steers load extraction.
  assign al_mode = idle ? mem_acc_mode : mode_q;
  assign al_alo  = idle ? addr[1:0]    : alo_q;

  lsu_align u_align (
    .mode_i      (al_mode),
    .addr_lo_i   (al_alo),
    .wdata_i     (wdata),
    .bus_rdata_i (bus_rdata),
    .be_o        (al_be),
    .wdata_o     (al_wdata),
    .rdata_o     (al_rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    fault_d = fault_q;
    we_d    = we_q;
    addr_d  = addr_q;
    alo_d   = alo_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    mode_d  = mode_q;
    unique case (state_q)
      IDLE: begin
        if (req_ok) begin
          we_d    = wr_en;
          addr_d  = addr[31:2];
          alo_d   = addr[1:0];
          be_d    = al_be;
          wdata_d = wr_en ? al_wdata : 32'h0;
          mode_d  = mem_acc_mode;
          cnt_d   = 16'h0;
          fault_d = 1'b0;
          state_d = REQ;
        end
      end
      REQ: begin
        if (bus_ready) begin
          rdata_d = (bus_err | we_q) ? 32'h0 : al_rdata;
          fault_d = bus_err;
          cnt_d   = 16'h0;
          state_d = DONE;
        end else if (cnt_q == TMO_LAST) begin
          rdata_d = 32'h0;
          fault_d = 1'b1;
          cnt_d   = 16'h0;
          state_d = DONE;
        end else if (cnt_q != 16'hFFFF) begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      DONE: begin
        rdata_d = 32'h0;
        fault_d = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 16'h0;
      rdata_q <= 32'h0;
      fault_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 30'h0;
      alo_q   <= 2'b00;
      be_q    <= 4'h0;
      wdata_q <= 32'h0;
      mode_q  <= 3'b000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      alo_q   <= alo_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      mode_q  <= mode_d;
    end
  end

  assign rdata        = rdata_q;
  assign bus_valid    = (state_q == REQ);
  assign stall_mem    = req_ok | bus_valid;
  assign misalign     = idle & req & legal & mis;
  assign access_fault = (idle & req & ~legal) | ((state_q == DONE) & fault_q);
  assign bus_we       = we_q;
  assign bus_addr     = {addr_q, 2'b00};
  assign bus_be       = be_q;
  assign bus_wdata    = wdata_q;

endmodule
